// File: rtl/axi_mem_sub.sv
// AXI4 subordinate backed by an internal word array. INCR write and read bursts are served by
// two independent FSMs. Each FSM has one transaction outstanding, and all handshake outputs are registered.
module axi_mem_sub #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int MEM_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  // write address channel
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  // write data channel
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                      s_axi_wlast,
  // write response channel
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  // read address channel
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  // read data channel
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      wlast_err
);

  localparam int LSB   = $clog2(AXI_STRB_WIDTH);
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam logic [MEM_ADDR_WIDTH-1:0] IDX_ONE = 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write-side state
  w_state_e                  w_state_q, w_state_d;
  logic [MEM_ADDR_WIDTH-1:0] w_idx_q, w_idx_d;
  logic [AXI_ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [7:0]                w_len_q, w_len_d;
  logic [7:0]                w_cnt_q, w_cnt_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic                      wlast_err_q, wlast_err_d;
  logic                      mem_we;
  logic                      w_final_beat;

  // Read-side state
  r_state_e                  r_state_q, r_state_d;
  logic [MEM_ADDR_WIDTH-1:0] r_idx_q, r_idx_d;
  logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [7:0]                r_len_q, r_len_d;
  logic [7:0]                r_cnt_q, r_cnt_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic                      rlast_q, rlast_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;
  logic                      rd_load;
  logic [MEM_ADDR_WIDTH-1:0] rd_idx;

  // Burst type/size are fixed to full-width INCR; upper address bits alias.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                           s_axi_awaddr, s_axi_araddr};

  assign w_final_beat = (w_cnt_q == w_len_q);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_d   = w_state_q;
    w_idx_d     = w_idx_q;
    w_id_d      = w_id_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    wlast_err_d = wlast_err_q;
    mem_we      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awready_q && s_axi_awvalid) begin
          w_idx_d   = s_axi_awaddr[LSB +: MEM_ADDR_WIDTH];
          w_id_d    = s_axi_awid;
          w_len_d   = s_axi_awlen;
          w_cnt_d   = 8'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wready_q && s_axi_wvalid) begin
          mem_we = 1'b1;
          // The beat count decides the end of the burst; wlast is only cross-checked.
          if (s_axi_wlast != w_final_beat) wlast_err_d = 1'b1;
          if (w_final_beat) begin
            w_state_d = W_RESP;
          end else begin
            w_idx_d = w_idx_q + IDX_ONE;
            w_cnt_d = w_cnt_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bvalid_q && s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    rlast_d   = rlast_q;
    rd_load   = 1'b0;
    rd_idx    = r_idx_q;
    case (r_state_q)
      R_IDLE: begin
        if (arready_q && s_axi_arvalid) begin
          r_idx_d   = s_axi_araddr[LSB +: MEM_ADDR_WIDTH];
          r_id_d    = s_axi_arid;
          r_len_d   = s_axi_arlen;
          r_cnt_d   = 8'd0;
          rlast_d   = (s_axi_arlen == 8'd0);
          rd_load   = 1'b1;
          rd_idx    = r_idx_d;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && s_axi_rready) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_idx_d = r_idx_q + IDX_ONE;
            r_cnt_d = r_cnt_q + 8'd1;
            rlast_d = (r_cnt_d == r_len_q);
            rd_load = 1'b1;
            rd_idx  = r_idx_d;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      w_idx_q     <= '0;
      w_id_q      <= '0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      wlast_err_q <= 1'b0;
      r_state_q   <= R_IDLE;
      r_idx_q     <= '0;
      r_id_q      <= '0;
      r_len_q     <= '0;
      r_cnt_q     <= '0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      w_state_q   <= w_state_d;
      w_idx_q     <= w_idx_d;
      w_id_q      <= w_id_d;
      w_len_q     <= w_len_d;
      w_cnt_q     <= w_cnt_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      wlast_err_q <= wlast_err_d;
      r_state_q   <= r_state_d;
      r_idx_q     <= r_idx_d;
      r_id_q      <= r_id_d;
      r_len_q     <= r_len_d;
      r_cnt_q     <= r_cnt_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      // Loads see the array before this edge's write commits, so collisions return old data.
      if (rd_load) rdata_q <= mem_q[rd_idx];
    end
  end

  // NOTE: the array has no reset; contents survive rst and only written bytes change.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rid     = r_id_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rlast   = rlast_q;
  assign wlast_err     = wlast_err_q;

endmodule

// File: doc/axi_mem_sub.md
# axi_mem_sub

AXI4 subordinate backed by an internal register-array memory: accepts INCR write bursts into the array and serves INCR read bursts from it. It is the responder side for the AXI memory testers and other AXI initiators in the example designs, so they can run in simulation and on boards without an external SRAM controller. Read and write channels run as independent state machines, each with one outstanding transaction.

## Interface
- AXI_ADDR_WIDTH, 20: byte address width.
- AXI_DATA_WIDTH, 16: data width; must be a multiple of 8.
- AXI_ID_WIDTH, 4: transaction ID width.
- AXI_STRB_WIDTH, AXI_DATA_WIDTH/8: write strobe width.
- MEM_ADDR_WIDTH, 8: word-index width; memory holds 2^MEM_ADDR_WIDTH words of AXI_DATA_WIDTH bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- s_axi_awvalid/awready  in/out  1  write-address handshake.
- s_axi_awaddr  in  AXI_ADDR_WIDTH.
- s_axi_awid  in  AXI_ID_WIDTH.
- s_axi_awlen  in  8  beats minus 1.
- s_axi_awsize  in  3; s_axi_awburst  in  2: both ignored.
- s_axi_wvalid/wready  in/out  1; s_axi_wdata  in  AXI_DATA_WIDTH; s_axi_wstrb  in  AXI_STRB_WIDTH; s_axi_wlast  in  1.
- s_axi_bvalid/bready  out/in  1; s_axi_bid  out  AXI_ID_WIDTH; s_axi_bresp  out  2.
- s_axi_arvalid/arready  in/out  1; s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst: as AW; arsize/arburst ignored.
- s_axi_rvalid/rready  out/in  1; s_axi_rid  out  AXI_ID_WIDTH; s_axi_rdata  out  AXI_DATA_WIDTH; s_axi_rresp  out  2; s_axi_rlast  out  1.
- wlast_err  out  1  sticky: wlast disagreed with awlen beat count.

## Operation
- Word index = addr[LSB +: MEM_ADDR_WIDTH], LSB = log2(AXI_STRB_WIDTH). Upper address bits ignored (aliasing). Index increments by 1 per beat and wraps modulo 2^MEM_ADDR_WIDTH.
- All bursts are treated as INCR, full-width beats. bresp and rresp are always 2'b00 (OKAY).
- Write FSM: W_IDLE (awready=1) -> on AW handshake capture index, id, len; beat counter=0 -> W_DATA.
  - W_DATA (wready=1): each W handshake writes the strobed bytes of wdata to mem[index]; index and counter increment.
  - The burst ends on the handshake where counter==len, regardless of wlast. If wlast differs from (counter==len) on any beat, wlast_err sets and stays set until rst.
  - End of burst -> W_RESP (bvalid=1, bid=captured id); on B handshake -> W_IDLE.
- Read FSM: R_IDLE (arready=1) -> on AR handshake capture index, id, len -> R_DATA.
  - R_DATA: rvalid=1, rid=captured id, rdata=registered mem word, rlast=(counter==len). rdata/rlast/rid hold stable while rvalid && !rready.
  - On an R handshake with !rlast: next word loaded, index and counter increment. With rlast: -> R_IDLE.
- Collision: read loading a word in the same cycle a write commits that word returns the old data.
- Memory contents are not reset.

## Timing
- While rst is high, and on the cycle it deasserts: all valid/ready outputs = 0, wlast_err = 0, both FSMs in IDLE. awready=arready=1 from the next cycle.
- AW handshake at cycle N -> wready=1 at N+1. awready=0 from N+1 until back in W_IDLE.
- Final W handshake at N -> bvalid=1 at N+1. B handshake at M -> awready=1 at M+1.
- AR handshake at N -> rvalid=1 with beat 0 at N+1. With rready held high, one beat per cycle; a len=L burst occupies cycles N+1..N+1+L.
- Last R handshake at M -> rvalid=0, arready=1 at M+1.
- Throughput floor: single-beat writes take 3 cycles each (AW, W, B); single-beat reads take 2.
- Write and read channels never stall each other.
- rst asserted mid-burst aborts both FSMs at the next edge. Partially written words stay written.

## Test plan
- Tester pattern: 8 write bursts, len=2, addr 0,6,12..42, data 0xD0..0xE7, then matching reads -> every rdata equals the written value, rlast on every 3rd beat, 8 B responses with bresp=0.
- Strobes: write 0xFFFF to word 5, then 0x1234 with wstrb=2'b10 -> read word 5 returns 0x12FF.
- Backpressure: random rready/bready drop and wvalid gaps -> no lost or duplicated beats, rdata stable while stalled, bvalid held until bready.
- Wrap: MEM_ADDR_WIDTH=4, 4-beat burst at word 14 -> words 14,15,0,1 written; read from byte address 0x20 (aliased word 0) returns beat 2.
- wlast_err: awlen=3 with wlast on beat 1 -> 4 beats accepted, one B response, wlast_err=1 until rst.
- Concurrency/reset: simultaneous write and read at same address -> old data returned. rst mid-read -> rvalid=0 next cycle, arready=1 the cycle after rst deasserts.
